fas_serial_ctrl: RTL

Bit-serial add/subtract sequencer built around a single `fas` full adder/subtractor cell. It accepts two WIDTH-bit operands and an operation on a start strobe. It then steps them LSB-first through the one `fas` instance, one bit per clock, while holding the carry/borrow in a flop. It delivers the WIDTH-bit result and the final carry/borrow with a one-cycle done pulse, so a narrow arithmetic resource can serve wide operands.

---
 rtl/fas_serial_pkg.sv | 14 +
 rtl/fas.sv | 22 ++
 rtl/fas_serial_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/fas_serial_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// Optional overflow flag is enabled with FAS_SERIAL_OVF_EN.
package fas_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fas_serial_state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/fas.sv
// Single-bit full adder/subtractor cell.
// a_ns=1 adds a+b+cin, a_ns=0 subtracts a-b-cin (cout is the borrow).
module fas
  import fas_serial_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic co_add;
  logic co_sub;

  assign s      = a ^ b ^ cin;
  assign co_add = (a & b) | (cin & (a ^ b));
  assign co_sub = (~a & b) | (cin & ~(a ^ b));
  assign cout   = (a_ns == OP_ADD) ? co_add : co_sub;

endmodule

// File: rtl/fas_serial_ctrl.sv
// Bit-serial add/subtract sequencer stepping operands LSB-first through one fas cell.
// Define FAS_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module fas_serial_ctrl
  import fas_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_add,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
`ifdef FAS_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  fas_serial_state_t state;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa_sh;
  logic [WIDTH-1:0] opb_sh;
  logic [WIDTH-1:0] res_sh;
  logic             op_q;
  logic             cy_q;
  logic             fas_s;
  logic             fas_co;

  fas u_fas (
    .a    (opa_sh[0]),
    .b    (opb_sh[0]),
    .cin  (cy_q),
    .a_ns (op_q),
    .s    (fas_s),
    .cout (fas_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      opa_sh <= '0;
      opb_sh <= '0;
      res_sh <= '0;
      op_q   <= OP_ADD;
      cy_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
`ifdef FAS_SERIAL_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            opa_sh <= opa;
            opb_sh <= opb;
            op_q   <= op_add;
            cy_q   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          opa_sh <= opa_sh >> 1;
          opb_sh <= opb_sh >> 1;
          res_sh <= {fas_s, res_sh[WIDTH-1:1]};
          cy_q   <= fas_co;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Outputs only move on the final bit so they stay stable otherwise.
            result <= {fas_s, res_sh[WIDTH-1:1]};
            carry  <= fas_co;
`ifdef FAS_SERIAL_OVF_EN
            ovf    <= cy_q ^ fas_co;
`endif
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
